// File: rtl/connect4_pkg.sv
// Shared types, board geometry, VGA timing and display constants for the Connect 4 game.
package connect4_pkg;

  localparam int unsigned ROWS  = 6;
  localparam int unsigned COLS  = 7;
  localparam int unsigned ROW_W = 3;
  localparam int unsigned COL_W = 3;
  localparam int unsigned CNT_W = 10;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_P1    = 2'b01,
    CELL_P2    = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    P1_TURN   = 2'd0,
    P2_TURN   = 2'd1,
    CHECK     = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  typedef logic [ROWS-1:0][COLS-1:0][1:0] board_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int unsigned H_VIS   = 640;
  localparam int unsigned H_FP    = 16;
  localparam int unsigned H_SYNC  = 96;
  localparam int unsigned H_BP    = 48;
  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_VIS   = 480;
  localparam int unsigned V_FP    = 10;
  localparam int unsigned V_SYNC  = 2;
  localparam int unsigned V_BP    = 33;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam int unsigned BOARD_X0    = 96;
  localparam int unsigned BOARD_Y0    = 48;
  localparam int unsigned CELL_PX     = 64;
  localparam int unsigned DISC_PX     = 48;
  localparam int unsigned DISC_MARGIN = (CELL_PX - DISC_PX) / 2;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;

  localparam rgb_t RGB_BLACK  = 24'h000000;
  localparam rgb_t RGB_RED    = 24'hFF0000;
  localparam rgb_t RGB_YELLOW = 24'hFFFF00;
  localparam rgb_t RGB_BLUE   = 24'h0000FF;
  localparam rgb_t RGB_WHITE  = 24'hFFFFFF;

  // Lowest empty row of a column; ROWS means the column is full or does not exist.
  function automatic logic [ROW_W-1:0] drop_row(input board_t b, input logic [COL_W-1:0] col);
    drop_row = ROW_W'(ROWS);
    if (32'(col) < COLS) begin
      for (int r = int'(ROWS) - 1; r >= 0; r--) begin
        if (b[r][col] == CELL_EMPTY) drop_row = ROW_W'(r);
      end
    end
  endfunction

  function automatic rgb_t cell_rgb(input logic [1:0] c);
    case (c)
      CELL_P1: cell_rgb = RGB_RED;
      CELL_P2: cell_rgb = RGB_YELLOW;
      default: cell_rgb = RGB_BLACK;
    endcase
  endfunction

  function automatic rgb_t winner_rgb(input logic [1:0] w);
    case (w)
      CELL_P1: winner_rgb = RGB_RED;
      CELL_P2: winner_rgb = RGB_YELLOW;
      default: winner_rgb = RGB_WHITE;
    endcase
  endfunction

  function automatic logic [6:0] seg_digit(input logic [1:0] w);
    case (w)
      CELL_P1: seg_digit = SEG_1;
      CELL_P2: seg_digit = SEG_2;
      default: seg_digit = SEG_0;
    endcase
  endfunction

endpackage

// File: rtl/connect4_win_checker.sv
// Combinational four-in-a-row detector over the whole board.
module connect4_win_checker
  import connect4_pkg::*;
(
  input  board_t     i_board,
  output logic       o_win_flag,
  output logic [1:0] o_winner_id
);

  function automatic logic four(input logic [1:0] a, b, c, d);
    return (a != CELL_EMPTY) && (a == b) && (a == c) && (a == d);
  endfunction

  // Loop ranges keep every index in bounds: horizontal, vertical, and both diagonals.
  always_comb begin
    o_win_flag  = 1'b0;
    o_winner_id = 2'b00;
    for (int r = 0; r < int'(ROWS); r++) begin
      for (int c = 0; c + 3 < int'(COLS); c++) begin
        if (four(i_board[r][c], i_board[r][c+1], i_board[r][c+2], i_board[r][c+3])) begin
          o_win_flag  = 1'b1;
          o_winner_id = i_board[r][c];
        end
      end
    end
    for (int r = 0; r + 3 < int'(ROWS); r++) begin
      for (int c = 0; c < int'(COLS); c++) begin
        if (four(i_board[r][c], i_board[r+1][c], i_board[r+2][c], i_board[r+3][c])) begin
          o_win_flag  = 1'b1;
          o_winner_id = i_board[r][c];
        end
      end
      for (int c = 0; c + 3 < int'(COLS); c++) begin
        if (four(i_board[r][c], i_board[r+1][c+1], i_board[r+2][c+2], i_board[r+3][c+3])) begin
          o_win_flag  = 1'b1;
          o_winner_id = i_board[r][c];
        end
      end
      for (int c = 3; c < int'(COLS); c++) begin
        if (four(i_board[r][c], i_board[r+1][c-1], i_board[r+2][c-2], i_board[r+3][c-3])) begin
          o_win_flag  = 1'b1;
          o_winner_id = i_board[r][c];
        end
      end
    end
  end

endmodule

// File: rtl/connect4_top.sv
// Connect 4 top: P1 button/switch input, P2 SPI input, turn FSM, 7-segment status and VGA board view.
module connect4_top
  import connect4_pkg::*;
#(
  parameter int unsigned PIX_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fsm_reset,
  input  logic       btn_confirm_p1,
  input  logic [2:0] switches_p1,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       spi_cs,
  output logic       hsync,
  output logic       vsync,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic [6:0] seg
);

  localparam int unsigned PD_W = $clog2(PIX_DIV + 1);

  board_t     r_board;
  state_t     r_state;
  logic [1:0] r_winner;
  logic       r_p2_moved;
  logic       win_flag;
  logic [1:0] winner_id;

  connect4_win_checker u_win_checker (
    .i_board     (r_board),
    .o_win_flag  (win_flag),
    .o_winner_id (winner_id)
  );

  // P1 confirm edge; during rst both flops track the pin so a press inside reset is not seen.
  logic r_btn_cur, r_btn_prev, w_p1_edge;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_btn_cur  <= btn_confirm_p1;
      r_btn_prev <= btn_confirm_p1;
    end else begin
      r_btn_cur  <= btn_confirm_p1;
      r_btn_prev <= r_btn_cur;
    end
  end
  assign w_p1_edge = r_btn_cur & ~r_btn_prev;

  // SPI mode 0 receiver; only the low three bits of the byte matter, so only those are kept.
  logic [1:0] r_sclk_sync, r_mosi_sync, r_cs_sync;
  logic       r_sclk_prev, r_spi_strobe, w_sclk_rise;
  logic [2:0] r_shift, r_bit_cnt;
  assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_prev;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync  <= 2'b00;
      r_mosi_sync  <= 2'b00;
      r_cs_sync    <= 2'b11;
      r_sclk_prev  <= 1'b0;
      r_shift      <= 3'd0;
      r_bit_cnt    <= 3'd0;
      r_spi_strobe <= 1'b0;
    end else begin
      r_sclk_sync  <= {r_sclk_sync[0], spi_clk};
      r_mosi_sync  <= {r_mosi_sync[0], spi_mosi};
      r_cs_sync    <= {r_cs_sync[0], spi_cs};
      r_sclk_prev  <= r_sclk_sync[1];
      r_spi_strobe <= 1'b0;
      if (r_cs_sync[1]) begin
        r_bit_cnt <= 3'd0;
      end else if (w_sclk_rise) begin
        r_shift   <= {r_shift[1:0], r_mosi_sync[1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) r_spi_strobe <= 1'b1;
      end
    end
  end

  logic             w_move, w_move_ok, w_top_full;
  logic [COL_W-1:0] w_move_col;
  logic [ROW_W-1:0] w_drop_row;
  cell_t            w_move_cell;
  always_comb begin
    w_move      = 1'b0;
    w_move_col  = switches_p1;
    w_move_cell = CELL_P1;
    if (r_state == P1_TURN) begin
      w_move = w_p1_edge;
    end else if (r_state == P2_TURN) begin
      w_move      = r_spi_strobe;
      w_move_col  = r_shift;
      w_move_cell = CELL_P2;
    end
    w_drop_row = drop_row(r_board, w_move_col);
    w_move_ok  = w_move && (w_drop_row < ROW_W'(ROWS));
    w_top_full = 1'b1;
    for (int c = 0; c < int'(COLS); c++) begin
      if (r_board[ROWS-1][c] == CELL_EMPTY) w_top_full = 1'b0;
    end
  end

  // Turn FSM; a live four-in-a-row preempts everything except GAME_OVER itself.
  always_ff @(posedge clk) begin
    if (rst || fsm_reset) begin
      r_state    <= P1_TURN;
      r_board    <= '0;
      r_winner   <= 2'b00;
      r_p2_moved <= 1'b0;
    end else if (r_state != GAME_OVER && win_flag) begin
      r_state  <= GAME_OVER;
      r_winner <= winner_id;
    end else begin
      case (r_state)
        P1_TURN, P2_TURN: begin
          if (w_move_ok) begin
            r_board[w_drop_row][w_move_col] <= w_move_cell;
            r_p2_moved                      <= (r_state == P2_TURN);
            r_state                         <= CHECK;
          end
        end
        CHECK: begin
          if (w_top_full) begin
            r_state  <= GAME_OVER;
            r_winner <= 2'b00;
          end else begin
            r_state <= r_p2_moved ? P1_TURN : P2_TURN;
          end
        end
        default: r_state <= GAME_OVER;
      endcase
    end
  end

  // CHECK already shows the player who moves next.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= SEG_1;
    end else begin
      case (r_state)
        P1_TURN: seg <= SEG_1;
        P2_TURN: seg <= SEG_2;
        CHECK:   seg <= r_p2_moved ? SEG_1 : SEG_2;
        default: seg <= seg_digit(r_winner);
      endcase
    end
  end

  // Pixel-enable divider and 800x525 raster counters.
  logic [PD_W-1:0]  r_pix_cnt;
  logic [CNT_W-1:0] r_h_cnt, r_v_cnt;
  logic             w_pix_en;
  assign w_pix_en = (r_pix_cnt == PD_W'(PIX_DIV - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pix_cnt <= '0;
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
    end else begin
      r_pix_cnt <= w_pix_en ? '0 : r_pix_cnt + PD_W'(1);
      if (w_pix_en) begin
        if (r_h_cnt == CNT_W'(H_TOTAL - 1)) begin
          r_h_cnt <= '0;
          r_v_cnt <= (r_v_cnt == CNT_W'(V_TOTAL - 1)) ? '0 : r_v_cnt + CNT_W'(1);
        end else begin
          r_h_cnt <= r_h_cnt + CNT_W'(1);
        end
      end
    end
  end

  logic [8:0]       w_bx, w_by;
  logic [ROW_W-1:0] w_cell_r;
  logic [COL_W-1:0] w_cell_c;
  logic             w_visible, w_in_board, w_in_disc, w_hs, w_vs;
  rgb_t             w_rgb;
  always_comb begin
    w_bx       = 9'(r_h_cnt - CNT_W'(BOARD_X0));
    w_by       = 9'(r_v_cnt - CNT_W'(BOARD_Y0));
    w_cell_c   = w_bx[8:6];
    w_cell_r   = ROW_W'(ROWS - 1) - w_by[8:6];
    w_visible  = (r_h_cnt < CNT_W'(H_VIS)) && (r_v_cnt < CNT_W'(V_VIS));
    w_in_board = (r_h_cnt >= CNT_W'(BOARD_X0)) && (r_h_cnt < CNT_W'(BOARD_X0 + COLS * CELL_PX))
              && (r_v_cnt >= CNT_W'(BOARD_Y0)) && (r_v_cnt < CNT_W'(BOARD_Y0 + ROWS * CELL_PX));
    w_in_disc  = (w_bx[5:0] >= 6'(DISC_MARGIN)) && (w_bx[5:0] < 6'(DISC_MARGIN + DISC_PX))
              && (w_by[5:0] >= 6'(DISC_MARGIN)) && (w_by[5:0] < 6'(DISC_MARGIN + DISC_PX));
    w_hs       = (r_h_cnt >= CNT_W'(H_VIS + H_FP)) && (r_h_cnt < CNT_W'(H_VIS + H_FP + H_SYNC));
    w_vs       = (r_v_cnt >= CNT_W'(V_VIS + V_FP)) && (r_v_cnt < CNT_W'(V_VIS + V_FP + V_SYNC));
    w_rgb      = RGB_BLACK;
    if (w_visible) begin
      if (w_in_board) begin
        w_rgb = w_in_disc ? cell_rgb(r_board[w_cell_r][w_cell_c]) : RGB_BLUE;
      end else if (r_state == GAME_OVER) begin
        w_rgb = winner_rgb(r_winner);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      red   <= 8'h00;
      green <= 8'h00;
      blue  <= 8'h00;
    end else begin
      hsync <= ~w_hs;
      vsync <= ~w_vs;
      red   <= w_rgb.r;
      green <= w_rgb.g;
      blue  <= w_rgb.b;
    end
  end

endmodule

// File: tb/tb_connect4_top.sv
// Directed bench for connect4_top: moves, SPI input, forced win, restart, full column, real win, VGA timing.
module tb_connect4_top;
  import connect4_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fsm_reset = 1'b0;
  logic       btn_confirm_p1 = 1'b0;
  logic [2:0] switches_p1 = 3'd0;
  logic       spi_clk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_cs = 1'b1;
  logic       hsync, vsync;
  logic [7:0] red, green, blue;
  logic [6:0] seg;

  int checks = 0;
  int errors = 0;

  connect4_top dut (
    .clk            (clk),
    .rst            (rst),
    .fsm_reset      (fsm_reset),
    .btn_confirm_p1 (btn_confirm_p1),
    .switches_p1    (switches_p1),
    .spi_clk        (spi_clk),
    .spi_mosi       (spi_mosi),
    .spi_cs         (spi_cs),
    .hsync          (hsync),
    .vsync          (vsync),
    .red            (red),
    .green          (green),
    .blue           (blue),
    .seg            (seg)
  );

  always #10 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic p1_move(input logic [2:0] col);
    switches_p1    = col;
    btn_confirm_p1 = 1'b1;
    tick(1);
    btn_confirm_p1 = 1'b0;
    tick(4);
  endtask

  task automatic spi_byte(input logic [7:0] b);
    spi_cs = 1'b0;
    #40;
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = b[i];
      #40 spi_clk = 1'b1;
      #40 spi_clk = 1'b0;
    end
    #40 spi_cs = 1'b1;
    tick(12);
  endtask

  int low;
  int per;
  int n;

  initial begin
    // Reset with the button held: values in reset, and no move once reset drops.
    btn_confirm_p1 = 1'b1;
    tick(2);
    check("rst_hsync", 32'(hsync), 32'd1);
    check("rst_vsync", 32'(vsync), 32'd1);
    check("rst_rgb", 32'({red, green, blue}), 32'h0);
    check("rst_seg", 32'(seg), 32'(7'b1111001));
    rst = 1'b0;
    tick(3);
    btn_confirm_p1 = 1'b0;
    tick(3);
    check("rst_edge_state", 32'(dut.r_state), 32'(P1_TURN));
    check("rst_edge_board", 32'(dut.r_board), 32'h0);

    // First P1 move into column 2, with latency checks.
    switches_p1    = 3'd2;
    btn_confirm_p1 = 1'b1;
    tick(1);
    btn_confirm_p1 = 1'b0;
    check("p1_n_state", 32'(dut.r_state), 32'(P1_TURN));
    tick(1);
    check("p1_n1_board", 32'(dut.r_board[0][2]), 32'd1);
    check("p1_n1_state", 32'(dut.r_state), 32'(CHECK));
    tick(1);
    check("p1_n2_state", 32'(dut.r_state), 32'(P2_TURN));
    tick(1);
    check("p1_seg", 32'(seg), 32'(7'b0100100));

    // P1 button during P2's turn is ignored.
    p1_move(3'd5);
    check("p2turn_btn_state", 32'(dut.r_state), 32'(P2_TURN));
    check("p2turn_btn_board", 32'(dut.r_board[0][5]), 32'd0);

    // P2 plays column 3 over SPI.
    spi_byte(8'h03);
    check("p2_board", 32'(dut.r_board[0][3]), 32'd2);
    check("p2_state", 32'(dut.r_state), 32'(P1_TURN));
    check("p2_seg", 32'(seg), 32'(7'b1111001));

    // Forced win by P2 during P1_TURN.
    force dut.win_flag = 1'b1;
    force dut.winner_id = 2'b10;
    tick(1);
    release dut.win_flag;
    release dut.winner_id;
    tick(2);
    check("force_state", 32'(dut.r_state), 32'(GAME_OVER));
    check("force_seg", 32'(seg), 32'(7'b0100100));
    p1_move(3'd0);
    spi_byte(8'h00);
    check("over_ignore_p1", 32'(dut.r_board[0][0]), 32'd0);
    check("over_ignore_p2", 32'(dut.r_board[1][0]), 32'd0);
    check("over_state", 32'(dut.r_state), 32'(GAME_OVER));

    // Game restart.
    fsm_reset = 1'b1;
    tick(1);
    fsm_reset = 1'b0;
    tick(2);
    check("fsmrst_board", 32'(dut.r_board), 32'h0);
    check("fsmrst_state", 32'(dut.r_state), 32'(P1_TURN));
    check("fsmrst_seg", 32'(seg), 32'(7'b1111001));

    // hsync timing after restart, and blank RGB during sync.
    n = 0;
    while (hsync !== 1'b1 && n < 4000) begin tick(1); n++; end
    n = 0;
    while (hsync !== 1'b0 && n < 4000) begin tick(1); n++; end
    check("hsync_blank_rgb", 32'({red, green, blue}), 32'h0);
    low = 0;
    while (hsync === 1'b0 && low < 4000) begin tick(1); low++; end
    per = low;
    while (hsync === 1'b1 && per < 4000) begin tick(1); per++; end
    check("hsync_low", 32'(low), 32'd192);
    check("hsync_period", 32'(per), 32'd1600);
    check("vsync_idle", 32'(vsync), 32'd1);

    // Column 7 does not exist.
    p1_move(3'd7);
    check("col7_state", 32'(dut.r_state), 32'(P1_TURN));
    check("col7_board", 32'(dut.r_board), 32'h0);

    // Fill column 4 alternately, then P1 tries the full column.
    for (int k = 0; k < 3; k++) begin
      p1_move(3'd4);
      spi_byte(8'h04);
    end
    check("col4_top", 32'(dut.r_board[5][4]), 32'd2);
    check("col4_bottom", 32'(dut.r_board[0][4]), 32'd1);
    p1_move(3'd4);
    check("full_state", 32'(dut.r_state), 32'(P1_TURN));
    check("full_seg", 32'(seg), 32'(7'b1111001));

    // P1 stacks column 0; P2 answers in column 1 (upper byte bits ignored on the first answer).
    p1_move(3'd0);
    spi_byte(8'hF9);
    check("p2_hibits", 32'(dut.r_board[0][1]), 32'd2);
    p1_move(3'd0);
    spi_byte(8'h01);
    p1_move(3'd0);
    spi_byte(8'h01);
    check("prewin_flag", 32'(dut.win_flag), 32'd0);
    p1_move(3'd0);
    check("win_flag", 32'(dut.win_flag), 32'd1);
    check("win_id", 32'(dut.winner_id), 32'd1);
    check("win_state", 32'(dut.r_state), 32'(GAME_OVER));
    check("win_seg", 32'(seg), 32'(7'b1111001));
    p1_move(3'd7);
    p1_move(3'd0);
    spi_byte(8'h01);
    check("win_ignore_p1", 32'(dut.r_board[4][0]), 32'd0);
    check("win_ignore_p2", 32'(dut.r_board[3][1]), 32'd0);
    check("win_hold_state", 32'(dut.r_state), 32'(GAME_OVER));

    // Outside the board shows the winner's colour, a few pixels into the line.
    n = 0;
    while (hsync !== 1'b0 && n < 4000) begin tick(1); n++; end
    n = 0;
    while (hsync !== 1'b1 && n < 4000) begin tick(1); n++; end
    tick(116);
    check("over_border_rgb", 32'({red, green, blue}), 32'h00FF0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
